// File: rtl/case4_pkg.sv
// case4_pkg: shared result type, width and saturating increment for the case4 collector.
package case4_pkg;
  localparam int RESULT_W = 3;
  typedef struct packed {
    logic x;
    logic y;
    logic z;
  } case4_result_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
    return (cnt >= max) ? cnt : cnt + 32'd1;
  endfunction
endpackage

// File: rtl/case4_result_fifo.sv
// case4_result_fifo: small result FIFO; full/empty derive from occupancy, pointers wrap naturally.
module case4_result_fifo
  import case4_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  case4_result_t            wr_data,
  output case4_result_t            rd_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  case4_result_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    occ_d    = occ_q + OW'(push) - OW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end
  assign rd_data   = mem_q[rd_ptr_q];
  assign occupancy = occ_q;
  assign full      = occ_q == OW'(DEPTH);
  assign empty     = occ_q == '0;
endmodule

// File: rtl/case4_result_collector.sv
// case4_result_collector: samples case4 {x,y,z} results into a FIFO and keeps saturating activity counters.
module case4_result_collector
  import case4_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic                   x,
  input  logic                   y,
  input  logic                   z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RESULT_W-1:0]    out_data,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       cnt_x,
  output logic [CNT_W-1:0]       cnt_y,
  output logic [CNT_W-1:0]       cnt_z,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   overflow
);
  localparam logic [31:0] MAX = 32'((64'd1 << CNT_W) - 64'd1);
  case4_result_t sample, head;
  logic full, empty, pop, push, drop;
  logic [CNT_W-1:0] cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d, cnt_z_q, cnt_z_d, drop_q, drop_d;
  logic overflow_q, overflow_d;
  assign sample    = case4_result_t'({x, y, z});
  assign out_valid = !empty;
  assign pop       = out_valid & out_ready;
  // a full FIFO still accepts when the head leaves on the same edge
  assign push      = in_valid & (!full | pop);
  assign drop      = in_valid & full & !pop;
  case4_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .wr_data   (sample),
    .rd_data   (head),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );
  always_comb begin
    cnt_x_d    = (in_valid & x) ? CNT_W'(sat_inc(32'(cnt_x_q), MAX)) : cnt_x_q;
    cnt_y_d    = (in_valid & y) ? CNT_W'(sat_inc(32'(cnt_y_q), MAX)) : cnt_y_q;
    cnt_z_d    = (in_valid & z) ? CNT_W'(sat_inc(32'(cnt_z_q), MAX)) : cnt_z_q;
    drop_d     = drop ? CNT_W'(sat_inc(32'(drop_q), MAX)) : drop_q;
    overflow_d = overflow_q | drop;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_x_q    <= '0;
      cnt_y_q    <= '0;
      cnt_z_q    <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      cnt_x_q    <= '0;
      cnt_y_q    <= '0;
      cnt_z_q    <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_x_q    <= cnt_x_d;
      cnt_y_q    <= cnt_y_d;
      cnt_z_q    <= cnt_z_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end
  assign out_data = head;
  assign cnt_x    = cnt_x_q;
  assign cnt_y    = cnt_y_q;
  assign cnt_z    = cnt_z_q;
  assign drop_cnt = drop_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_case4_result_collector.sv
// tb_case4_result_collector: scoreboard bench with a queue-based reference model and random traffic.
module tb_case4_result_collector;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int SAT = 15;
  logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, x = 0, y = 0, z = 0, out_ready = 0;
  logic out_valid, overflow;
  logic [2:0] out_data;
  logic [2:0] occupancy;
  logic [CNT_W-1:0] cnt_x, cnt_y, cnt_z, drop_cnt;
  int checks = 0, errors = 0;
  logic [2:0] sb[$];
  int mx = 0, my = 0, mz = 0, md = 0;
  bit movf = 0, mpop, mfull;

  case4_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .x(x), .y(y), .z(z), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy), .cnt_x(cnt_x), .cnt_y(cnt_y),
    .cnt_z(cnt_z), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // reference model: FIFO as a queue, counters as saturating integers
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      sb.delete();
      mx = 0; my = 0; mz = 0; md = 0; movf = 0;
    end else begin
      mpop  = sb.size() > 0 && out_ready;
      mfull = sb.size() == DEPTH;
      if (in_valid) begin
        if (x && mx < SAT) mx++;
        if (y && my < SAT) my++;
        if (z && mz < SAT) mz++;
        if (mfull && !mpop) begin
          if (md < SAT) md++;
          movf = 1;
        end
      end
      if (mpop) void'(sb.pop_front());
      if (in_valid && (!mfull || mpop)) sb.push_back({x, y, z});
    end
  end

  // monitor: compares every observable output against the model mid-cycle
  always @(negedge clk) begin
    chk("occupancy", 32'(occupancy), sb.size());
    chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
    if (out_valid && sb.size() > 0) chk("out_data", 32'(out_data), 32'(sb[0]));
    chk("cnt_x", 32'(cnt_x), mx);
    chk("cnt_y", 32'(cnt_y), my);
    chk("cnt_z", 32'(cnt_z), mz);
    chk("drop_cnt", 32'(drop_cnt), md);
    chk("overflow", 32'(overflow), 32'(movf));
  end

  task automatic step(input logic iv, input logic [2:0] d, input logic rdy, input logic clr);
    in_valid = iv; {x, y, z} = d; out_ready = rdy; clear = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_valid"}, 32'(out_valid), 0);
    chk({n, "_data"}, 32'(out_data), 0);
    chk({n, "_occ"}, 32'(occupancy), 0);
    chk({n, "_cnt"}, 32'({cnt_x, cnt_y, cnt_z}), 0);
    chk({n, "_drop"}, 32'(drop_cnt), 0);
    chk({n, "_ovf"}, 32'(overflow), 0);
  endtask

  initial begin
    #3 chk_zero("rst0");
    @(posedge clk); #2 rst_n = 1;
    // single pass
    step(1, 3'b101, 0, 0);
    chk("sp_valid", 32'(out_valid), 1);
    chk("sp_data", 32'(out_data), 3'b101);
    chk("sp_occ", 32'(occupancy), 1);
    chk("sp_cnt", 32'({cnt_x, cnt_y, cnt_z}), {4'd1, 4'd0, 4'd1});
    step(0, 3'b000, 1, 0);
    // fill and overflow
    step(0, 3'b000, 0, 1);
    repeat (6) step(1, 3'($urandom), 0, 0);
    chk("fill_occ", 32'(occupancy), 4);
    chk("fill_drop", 32'(drop_cnt), 2);
    chk("fill_ovf", 32'(overflow), 1);
    repeat (4) step(0, 3'b000, 1, 0);
    chk("drain_occ", 32'(occupancy), 0);
    chk("drain_ovf", 32'(overflow), 1);
    // full push+pop
    step(0, 3'b000, 0, 1);
    repeat (4) step(1, 3'($urandom), 0, 0);
    repeat (5) step(1, 3'($urandom), 1, 0);
    chk("pp_occ", 32'(occupancy), 4);
    chk("pp_drop", 32'(drop_cnt), 0);
    repeat (4) step(0, 3'b000, 1, 0);
    // clear priority
    repeat (2) step(1, 3'b111, 0, 0);
    step(1, 3'b111, 1, 1);
    chk("clr_occ", 32'(occupancy), 0);
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_cnt", 32'({cnt_x, cnt_y, cnt_z}), 0);
    chk("clr_ovf", 32'(overflow), 0);
    // saturation
    repeat (20) step(1, 3'b100, 1, 0);
    chk("sat_x", 32'(cnt_x), SAT);
    step(1, 3'b100, 1, 0);
    chk("sat_hold", 32'(cnt_x), SAT);
    // asynchronous reset with 3 entries held
    step(0, 3'b000, 0, 1);
    repeat (3) step(1, 3'b110, 0, 0);
    chk("pre_rst_occ", 32'(occupancy), 3);
    in_valid = 0;
    #1 rst_n = 0;
    #1 chk_zero("rst_mid");
    @(posedge clk); #2 rst_n = 1;
    // random traffic
    repeat (1500) step($urandom % 4 != 0, 3'($urandom), $urandom % 3 != 0, $urandom % 60 == 0);
    step(0, 3'b000, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
